// File: rtl/aww_types_pkg.sv
// Arbiter state encoding and default dcache streak limit for the cache memory controller.
// Pure constants; no timing or flow control of their own.
package aww_types_pkg;
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t SERVE_D = 2'd1;
    localparam arb_state_t SERVE_I = 2'd2;

    localparam int MAX_D_STREAK_DEFAULT = 4;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake status.
// Pure type definitions; no timing or flow control of their own.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/cache_arb_pick.sv
// IDLE-state grant decision between dcache and icache.
// Combinational, zero latency; the caller registers the result.
module cache_arb_pick
    import aww_types_pkg::*;
(
    input  logic       d_req,
    input  logic       i_req,
    input  logic       lock_hit,
    input  logic       streak_full,
    output arb_state_t pick
);

    // Second word of a locked block beats a starving icache.
    always_comb begin
        pick = IDLE;
        if (d_req && lock_hit)
            pick = SERVE_D;
        else if (i_req && streak_full)
            pick = SERVE_I;
        else if (d_req)
            pick = SERVE_D;
        else if (i_req)
            pick = SERVE_I;
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Arbitrates dcache/icache onto one RAM port; wait low in the ACCESS cycle, >=2 cycles after request.
// RAM stalls (BUSY/FREE/ERROR) hold strobes and keep wait high; requesters may withdraw before ACCESS.
module cache_mem_ctrl
    import cpu_types_pkg::*;
    import aww_types_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t    state;
    arb_state_t    pick;
    logic [SW-1:0] streak;
    logic          lock_v;
    logic [28:0]   lock_blk;

    logic d_req;
    logic lock_hit;
    logic streak_full;
    logic ram_done;
    logic d_done;

    assign d_req       = dREN | dWEN;
    assign lock_hit    = lock_v && (daddr[31:3] == lock_blk);
    assign streak_full = (streak == SW'(MAX_D_STREAK));
    assign ram_done    = (ramstate == ACCESS);
    assign d_done      = (state == SERVE_D) && d_req && ram_done;

    cache_arb_pick u_pick (
        .d_req       (d_req),
        .i_req       (iREN),
        .lock_hit    (lock_hit),
        .streak_full (streak_full),
        .pick        (pick)
    );

    // Strobes follow the live request so a withdrawal drops them in the same cycle.
    always_comb begin
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            SERVE_D: begin
                if (d_req) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ram_done) begin
                        dwait = 1'b0;
                        dload = dWEN ? '0 : ramload;
                    end
                end
            end
            SERVE_I: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            streak   <= '0;
            lock_v   <= 1'b0;
            lock_blk <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= pick;
                    if (!(d_req && lock_hit))
                        lock_v <= 1'b0;
                    if (pick == SERVE_I || !iREN)
                        streak <= '0;
                    else if (pick == SERVE_D && !streak_full)
                        streak <= streak + SW'(1);
                end
                SERVE_D: begin
                    if (!d_req || ram_done)
                        state <= IDLE;
                    // Even-word completion opens a block so its odd partner follows unbroken.
                    if (d_done) begin
                        lock_v <= ~daddr[2];
                        if (!daddr[2])
                            lock_blk <= daddr[31:3];
                    end
                end
                SERVE_I: begin
                    if (!iREN || ram_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: scripted RAM model, per-cycle reference checks, completion-order log.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_cache_mem_ctrl;
    import cpu_types_pkg::*;

    typedef struct {
        logic  wen;
        word_t addr;
        word_t data;
    } dop_t;

    logic      CLK = 1'b0;
    logic      RST;
    logic      dREN, dWEN, iREN;
    word_t     daddr, dstore, iaddr;
    logic      dwait, iwait, ramREN, ramWEN;
    word_t     dload, iload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int checks   = 0;
    int failures = 0;

    int ram_lat   = 1;
    int err_start = 99;
    int ram_cnt   = 0;

    dop_t        d_ops[$];
    word_t       i_ops[$];
    logic [7:0]  log_who[$];
    word_t       log_addr[$];

    always #5 CLK = ~CLK;

    cache_mem_ctrl #(.MAX_D_STREAK(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    // RAM contents as a pure function of address.
    function automatic word_t mem_fn(input word_t a);
        if (a == 32'h40)
            return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: counts cycles a strobe has been held, BUSY then optional ERROR, then ACCESS.
    always @(posedge CLK)
        ram_cnt <= (ramREN | ramWEN) ? ram_cnt + 1 : 0;

    always_comb begin
        ramstate = FREE;
        if (ramREN | ramWEN) begin
            if (ram_cnt >= ram_lat)
                ramstate = ACCESS;
            else if (ram_cnt >= err_start)
                ramstate = ERROR;
            else
                ramstate = BUSY;
        end
    end

    assign ramload = mem_fn(ramaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic d_run();
        dop_t op;
        int   n;
        while (d_ops.size() > 0) begin
            op = d_ops.pop_front();
            dREN = 1'b1; dWEN = op.wen; daddr = op.addr; dstore = op.data;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (dwait && n < 100);
            chk("d_done_in_time", 32'(dwait), 32'd0);
            nxt();
        end
        dREN = 1'b0; dWEN = 1'b0;
    endtask

    task automatic i_run();
        int n;
        while (i_ops.size() > 0) begin
            iREN = 1'b1; iaddr = i_ops.pop_front();
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (iwait && n < 100);
            chk("i_done_in_time", 32'(iwait), 32'd0);
            nxt();
        end
        iREN = 1'b0;
    endtask

    // Per-cycle reference checks derived from the interface rules.
    task automatic compare_loop();
        logic prev_rst = 1'b1;
        forever begin
            @(negedge CLK);
            chk("one_completion_per_cycle", 32'(dwait | iwait), 32'd1);
            chk("strobes_exclusive", 32'(ramREN & ramWEN), 32'd0);
            if (prev_rst) begin
                chk("post_reset_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
                chk("post_reset_waits", {30'd0, dwait, iwait}, 32'd3);
            end
            if (!dwait) begin
                chk("d_req_at_completion", 32'(dREN | dWEN), 32'd1);
                chk("dload", dload, dWEN ? 32'd0 : mem_fn(daddr));
                chk("d_ramWEN", 32'(ramWEN), 32'(dWEN));
                chk("d_ramaddr", ramaddr, daddr);
                log_who.push_back(8'h44);
                log_addr.push_back(daddr);
            end else begin
                chk("dload_idle", dload, 32'd0);
            end
            if (!iwait) begin
                chk("i_req_at_completion", 32'(iREN), 32'd1);
                chk("iload", iload, mem_fn(iaddr));
                chk("i_ramWEN", 32'(ramWEN), 32'd0);
                chk("i_ramaddr", ramaddr, iaddr);
                log_who.push_back(8'h49);
                log_addr.push_back(iaddr);
            end else begin
                chk("iload_idle", iload, 32'd0);
            end
            prev_rst = RST;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        daddr = '0; dstore = '0; iaddr = '0;
        @(posedge CLK);
        fork
            compare_loop();
        join_none
        nxt();

        // Reset state
        @(negedge CLK);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_iload", iload, 32'd0);
        nxt();
        RST = 1'b0;
        nxt();

        // Single icache read: grant at cycle 1, completion at cycle 2
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK);
        chk("rd_c0_ramREN", 32'(ramREN), 32'd0);
        nxt(); @(negedge CLK);
        chk("rd_c1_ramREN", 32'(ramREN), 32'd1);
        chk("rd_c1_ramaddr", ramaddr, 32'h40);
        chk("rd_c1_iwait", 32'(iwait), 32'd1);
        nxt(); @(negedge CLK);
        chk("rd_c2_iwait", 32'(iwait), 32'd0);
        chk("rd_c2_iload", iload, 32'hDEADBEEF);
        chk("rd_c2_ramWEN", 32'(ramWEN), 32'd0);
        nxt(); iREN = 1'b0;
        @(negedge CLK);
        chk("rd_c3_iwait", 32'(iwait), 32'd1);
        nxt();

        // dcache write, dWEN wins over dREN
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h12;
        nxt(); @(negedge CLK);
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h3100);
        chk("wr_ramstore", ramstore, 32'h12);
        chk("wr_c1_dwait", 32'(dwait), 32'd1);
        nxt(); @(negedge CLK);
        chk("wr_c2_dwait", 32'(dwait), 32'd0);
        chk("wr_c2_dload", dload, 32'd0);
        nxt(); dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        chk("wr_c3_dwait", 32'(dwait), 32'd1);
        nxt();

        // RAM stall: 5 BUSY, 2 ERROR, then ACCESS
        ram_lat = 7; err_start = 5;
        dREN = 1'b1; daddr = 32'h208;
        for (int k = 1; k <= 7; k++) begin
            nxt(); @(negedge CLK);
            chk("stall_dwait", 32'(dwait), 32'd1);
            chk("stall_ramREN", 32'(ramREN), 32'd1);
            chk("stall_ramaddr", ramaddr, 32'h208);
        end
        nxt(); @(negedge CLK);
        chk("stall_done_dwait", 32'(dwait), 32'd0);
        chk("stall_done_dload", dload, 32'h0208FDF7);
        nxt(); dREN = 1'b0; ram_lat = 1; err_start = 99;
        nxt();

        // Reset while serving dcache
        ram_lat = 20;
        dREN = 1'b1; daddr = 32'h30C;
        nxt(); @(negedge CLK);
        chk("rs_c1_ramREN", 32'(ramREN), 32'd1);
        nxt(); RST = 1'b1;
        @(negedge CLK);
        chk("rs_c2_ramREN", 32'(ramREN), 32'd1);
        nxt(); @(negedge CLK);
        chk("rs_c3_ramREN", 32'(ramREN), 32'd0);
        chk("rs_c3_ramWEN", 32'(ramWEN), 32'd0);
        chk("rs_c3_dwait", 32'(dwait), 32'd1);
        nxt(); RST = 1'b0; dREN = 1'b0; ram_lat = 1;
        nxt();

        // icache withdraws mid-serve, then re-requests from IDLE
        ram_lat = 20;
        iREN = 1'b1; iaddr = 32'h80;
        nxt(); @(negedge CLK);
        chk("wd_c1_ramREN", 32'(ramREN), 32'd1);
        nxt(); iREN = 1'b0;
        @(negedge CLK);
        chk("wd_c2_ramREN", 32'(ramREN), 32'd0);
        chk("wd_c2_iwait", 32'(iwait), 32'd1);
        nxt(); iREN = 1'b1; ram_lat = 1;
        @(negedge CLK);
        chk("wd_c3_idle_ramREN", 32'(ramREN), 32'd0);
        chk("wd_c3_iwait", 32'(iwait), 32'd1);
        nxt(); @(negedge CLK);
        chk("wd_c4_ramREN", 32'(ramREN), 32'd1);
        nxt(); @(negedge CLK);
        chk("wd_c5_iwait", 32'(iwait), 32'd0);
        chk("wd_c5_iload", iload, 32'h0080FF7F);
        nxt(); iREN = 1'b0;
        nxt();

        // Contention: every fifth completion goes to icache
        log_who.delete(); log_addr.delete();
        for (int k = 0; k < 8; k++) d_ops.push_back('{1'b0, 32'h204, 32'h0});
        i_ops.push_back(32'h40); i_ops.push_back(32'h44);
        fork
            d_run();
            i_run();
        join
        nxt();
        chk("cont_count", 32'(log_who.size()), 32'd10);
        for (int k = 0; k < 10 && k < log_who.size(); k++)
            chk($sformatf("cont_order_%0d", k), 32'(log_who[k]), (k % 5 == 4) ? 32'h49 : 32'h44);

        // Block lock: even/odd pair stays together even with streak at its limit
        log_who.delete(); log_addr.delete();
        for (int k = 0; k < 3; k++) d_ops.push_back('{1'b0, 32'h20C, 32'h0});
        d_ops.push_back('{1'b1, 32'h100, 32'hA0});
        d_ops.push_back('{1'b1, 32'h104, 32'hA1});
        i_ops.push_back(32'h60);
        fork
            d_run();
            i_run();
        join
        nxt();
        chk("lock_count", 32'(log_who.size()), 32'd6);
        if (log_who.size() == 6) begin
            chk("lock_w0_who", 32'(log_who[3]), 32'h44);
            chk("lock_w0_addr", log_addr[3], 32'h100);
            chk("lock_w1_who", 32'(log_who[4]), 32'h44);
            chk("lock_w1_addr", log_addr[4], 32'h104);
            chk("lock_next_who", 32'(log_who[5]), 32'h49);
            chk("lock_next_addr", log_addr[5], 32'h60);
        end

        repeat (2) nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
